id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-002 SHALL have inputs: ID_valid 1; ID_inst 32; ID_pc 32; ID_rsdata 32; ID_rtdata 32; ID_imm 32; ID_aluop 4; ID_regread1 1; ID_regread2 1; ID_regwrite 1; ID_wraddr 5; ID_memread 1; ID_memwrite 1 (decoded ID-stage fields).
REQ-003 SHALL have inputs: hzdlu 1, load-use hazard from forwarding unit; fwdrs 2, fwdrt 2, forwarding selects (0 none, 1 MEM, 2 WB); WB_wrdata 32, WB result; flush 1, kill request from a later stage.
REQ-004 SHALL have outputs EX_valid, EX_inst, EX_pc, EX_rsdata, EX_rtdata, EX_imm, EX_aluop, EX_regread1, EX_regread2, EX_regwrite, EX_wraddr, EX_memread, EX_memwrite: registered copies, same widths as ID_*.
REQ-005 SHALL have outputs: ID_stall 1, freeze PC and IF/ID; EX_bubble 1, EX/MEM register loads a bubble; stall_cnt 16, flush_cnt 16, saturating event counters.

Function
REQ-006 stall SHALL be hzdlu & EX_valid & ~flush; ID_stall = stall, combinational.
REQ-007 EX_bubble SHALL equal stall.
REQ-008 Per cycle priority SHALL be: flush > stall > load.
REQ-009 flush: next cycle register holds bubble regardless of ID_valid or hzdlu.
REQ-010 Bubble SHALL mean EX_valid=0, EX_inst=32'h0, all control bits 0, EX_wraddr=0, all data fields 0.
REQ-011 stall: all EX_* fields SHALL hold, except EX_rsdata <= WB_wrdata when fwdrs==2 and EX_rtdata <= WB_wrdata when fwdrt==2 (capture WB value retiring during the stall).
REQ-012 load: if ID_valid=1 all ID_* fields SHALL be captured and EX_valid<=1; if ID_valid=0 bubble loaded.
REQ-013 Latency ID->EX SHALL be exactly one cycle when not stalled.
REQ-014 A hold SHALL last while stall is true; stall depends only on current inputs (no internal stall state).
REQ-015 stall_cnt SHALL increment by 1 each cycle stall=1, saturating at 16'hFFFF.
REQ-016 flush_cnt SHALL increment by 1 each cycle flush=1 and EX_valid=1 (real instruction killed), saturating at 16'hFFFF.
REQ-017 hzdlu with EX_valid=0 SHALL be ignored (no stall, normal load).
REQ-018 flush and hzdlu simultaneous: no stall, bubble loaded, stall_cnt unchanged, flush_cnt counts if EX_valid=1.

Reset
REQ-019 rst_n=0 SHALL asynchronously force the bubble state (REQ-010) and stall_cnt=flush_cnt=0.
REQ-020 ID_stall and EX_bubble SHALL be 0 during reset (follow from EX_valid=0).
REQ-021 Reset mid-stall SHALL discard the held instruction; first edge after deassert performs a normal load.

Structure
REQ-022 Shared package mips_pkg SHALL hold FWD_NONE=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2, NOP_INST=32'h0, CNT_W=16.
REQ-023 One sub-module sat_cnt (CNT_W-bit increment-enable saturating counter, async active-low reset) SHALL be instantiated twice.
REQ-024 ID_stall/EX_bubble SHALL be the only combinational outputs; all other outputs direct flop outputs.

Verification
REQ-025 Reset: rst_n=0 mid-cycle -> EX_valid=0, EX_inst=0, counters 0 immediately, no clock needed.
REQ-026 Pass-through: ID_valid=1, ID_inst=32'h8C22_0004, ID_pc=32'h40 -> next edge EX_inst=32'h8C22_0004, EX_pc=32'h40, EX_valid=1, ID_stall=0.
REQ-027 Load-use: EX_valid=1, hzdlu=1, fwdrt=2, WB_wrdata=32'hDEAD_BEEF for one cycle -> ID_stall=1, EX_bubble=1, EX_inst unchanged, EX_rtdata=32'hDEAD_BEEF after edge, stall_cnt=1.
REQ-028 Flush beats stall: EX_valid=1, hzdlu=1, flush=1 -> ID_stall=0, next edge EX_valid=0, flush_cnt=1, stall_cnt=0.
REQ-029 Saturation: stall forced 65 540 cycles -> stall_cnt=16'hFFFF, no wrap.
REQ-030 Idle hazard: EX_valid=0, hzdlu=1, ID_valid=1 -> ID_stall=0, instruction loaded next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the ID/EX pipeline register.
//   FWD_*     : forwarding-select encodings (none / from MEM / from WB)
//   NOP_INST  : instruction word that is placed in a bubble
//   CNT_W     : width of the saturating event counters
//   id_ex_t   : the complete ID/EX register contents
//   ID_EX_BUBBLE : the register contents of an empty (killed) stage
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [1:0]  FWD_NONE = 2'd0;
    localparam logic [1:0]  FWD_MEM  = 2'd1;
    localparam logic [1:0]  FWD_WB   = 2'd2;
    localparam logic [31:0] NOP_INST = 32'h0;
    localparam int          CNT_W    = 16;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rsdata;
        logic [31:0] rtdata;
        logic [31:0] imm;
        logic [3:0]  aluop;
        logic        regread1;
        logic        regread2;
        logic        regwrite;
        logic [4:0]  wraddr;
        logic        memread;
        logic        memwrite;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '{
        valid:    1'b0,
        inst:     NOP_INST,
        pc:       32'h0,
        rsdata:   32'h0,
        rtdata:   32'h0,
        imm:      32'h0,
        aluop:    4'h0,
        regread1: 1'b0,
        regread2: 1'b0,
        regwrite: 1'b0,
        wraddr:   5'd0,
        memread:  1'b0,
        memwrite: 1'b0
    };

endpackage

// File: rtl/sat_cnt.sv
// -----------------------------------------------------------------------------
// sat_cnt
// Increment-enable up counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   en    : increment request for this cycle
//   count : current count value (flop output)
// -----------------------------------------------------------------------------
module sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// -----------------------------------------------------------------------------
// id_ex_reg
// ID/EX pipeline register with load-use stall, flush and event counters.
//   clk, rst_n      : clock and asynchronous active-low reset
//   ID_*            : decoded instruction fields from the ID stage
//   hzdlu           : load-use hazard indication from the forwarding unit
//   fwdrs, fwdrt    : forwarding selects for rs/rt (none / MEM / WB)
//   WB_wrdata       : result currently being written back
//   flush           : kill request from a later stage
//   EX_*            : registered copies of the ID_* fields
//   ID_stall        : freeze PC and IF/ID (combinational)
//   EX_bubble       : EX/MEM loads a bubble (combinational, equals ID_stall)
//   stall_cnt       : saturating count of stall cycles
//   flush_cnt       : saturating count of killed valid instructions
// Priority per cycle is flush, then stall, then normal load.
// -----------------------------------------------------------------------------
module id_ex_reg
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,

    input  logic             ID_valid,
    input  logic [31:0]      ID_inst,
    input  logic [31:0]      ID_pc,
    input  logic [31:0]      ID_rsdata,
    input  logic [31:0]      ID_rtdata,
    input  logic [31:0]      ID_imm,
    input  logic [3:0]       ID_aluop,
    input  logic             ID_regread1,
    input  logic             ID_regread2,
    input  logic             ID_regwrite,
    input  logic [4:0]       ID_wraddr,
    input  logic             ID_memread,
    input  logic             ID_memwrite,

    input  logic             hzdlu,
    input  logic [1:0]       fwdrs,
    input  logic [1:0]       fwdrt,
    input  logic [31:0]      WB_wrdata,
    input  logic             flush,

    output logic             EX_valid,
    output logic [31:0]      EX_inst,
    output logic [31:0]      EX_pc,
    output logic [31:0]      EX_rsdata,
    output logic [31:0]      EX_rtdata,
    output logic [31:0]      EX_imm,
    output logic [3:0]       EX_aluop,
    output logic             EX_regread1,
    output logic             EX_regread2,
    output logic             EX_regwrite,
    output logic [4:0]       EX_wraddr,
    output logic             EX_memread,
    output logic             EX_memwrite,

    output logic             ID_stall,
    output logic             EX_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    id_ex_t ex_q;
    id_ex_t id_in;
    logic   stall;

    // A hazard against an empty EX stage is meaningless, and a flush kills
    // the instruction anyway, so neither of those may freeze the front end.
    assign stall     = hzdlu & ex_q.valid & ~flush;
    assign ID_stall  = stall;
    assign EX_bubble = stall;

    always_comb begin
        id_in          = ID_EX_BUBBLE;
        id_in.valid    = 1'b1;
        id_in.inst     = ID_inst;
        id_in.pc       = ID_pc;
        id_in.rsdata   = ID_rsdata;
        id_in.rtdata   = ID_rtdata;
        id_in.imm      = ID_imm;
        id_in.aluop    = ID_aluop;
        id_in.regread1 = ID_regread1;
        id_in.regread2 = ID_regread2;
        id_in.regwrite = ID_regwrite;
        id_in.wraddr   = ID_wraddr;
        id_in.memread  = ID_memread;
        id_in.memwrite = ID_memwrite;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= ID_EX_BUBBLE;
        end else if (flush) begin
            ex_q <= ID_EX_BUBBLE;
        end else if (stall) begin
            // Held instruction keeps everything, but a WB result retiring
            // during the stall would otherwise be lost before EX uses it.
            if (fwdrs == FWD_WB) begin
                ex_q.rsdata <= WB_wrdata;
            end
            if (fwdrt == FWD_WB) begin
                ex_q.rtdata <= WB_wrdata;
            end
        end else if (ID_valid) begin
            ex_q <= id_in;
        end else begin
            ex_q <= ID_EX_BUBBLE;
        end
    end

    assign EX_valid    = ex_q.valid;
    assign EX_inst     = ex_q.inst;
    assign EX_pc       = ex_q.pc;
    assign EX_rsdata   = ex_q.rsdata;
    assign EX_rtdata   = ex_q.rtdata;
    assign EX_imm      = ex_q.imm;
    assign EX_aluop    = ex_q.aluop;
    assign EX_regread1 = ex_q.regread1;
    assign EX_regread2 = ex_q.regread2;
    assign EX_regwrite = ex_q.regwrite;
    assign EX_wraddr   = ex_q.wraddr;
    assign EX_memread  = ex_q.memread;
    assign EX_memwrite = ex_q.memwrite;

    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall),
        .count (stall_cnt)
    );

    // Only real instructions being killed are counted.
    sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flush & ex_q.valid),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_id_ex_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_reg
// Directed table of per-cycle vectors with hand-computed expected register
// contents, followed by reset, reset-during-stall and counter saturation
// sequences.
// -----------------------------------------------------------------------------
module tb_id_ex_reg;

    logic        clk;
    logic        rst_n;
    logic        ID_valid;
    logic [31:0] ID_inst, ID_pc, ID_rsdata, ID_rtdata, ID_imm;
    logic [3:0]  ID_aluop;
    logic        ID_regread1, ID_regread2, ID_regwrite, ID_memread, ID_memwrite;
    logic [4:0]  ID_wraddr;
    logic        hzdlu;
    logic [1:0]  fwdrs, fwdrt;
    logic [31:0] WB_wrdata;
    logic        flush;

    logic        EX_valid;
    logic [31:0] EX_inst, EX_pc, EX_rsdata, EX_rtdata, EX_imm;
    logic [3:0]  EX_aluop;
    logic        EX_regread1, EX_regread2, EX_regwrite, EX_memread, EX_memwrite;
    logic [4:0]  EX_wraddr;
    logic        ID_stall, EX_bubble;
    logic [15:0] stall_cnt, flush_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    id_ex_reg dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ID_valid    (ID_valid),
        .ID_inst     (ID_inst),
        .ID_pc       (ID_pc),
        .ID_rsdata   (ID_rsdata),
        .ID_rtdata   (ID_rtdata),
        .ID_imm      (ID_imm),
        .ID_aluop    (ID_aluop),
        .ID_regread1 (ID_regread1),
        .ID_regread2 (ID_regread2),
        .ID_regwrite (ID_regwrite),
        .ID_wraddr   (ID_wraddr),
        .ID_memread  (ID_memread),
        .ID_memwrite (ID_memwrite),
        .hzdlu       (hzdlu),
        .fwdrs       (fwdrs),
        .fwdrt       (fwdrt),
        .WB_wrdata   (WB_wrdata),
        .flush       (flush),
        .EX_valid    (EX_valid),
        .EX_inst     (EX_inst),
        .EX_pc       (EX_pc),
        .EX_rsdata   (EX_rsdata),
        .EX_rtdata   (EX_rtdata),
        .EX_imm      (EX_imm),
        .EX_aluop    (EX_aluop),
        .EX_regread1 (EX_regread1),
        .EX_regread2 (EX_regread2),
        .EX_regwrite (EX_regwrite),
        .EX_wraddr   (EX_wraddr),
        .EX_memread  (EX_memread),
        .EX_memwrite (EX_memwrite),
        .ID_stall    (ID_stall),
        .EX_bubble   (EX_bubble),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl bit order: {regread1, regread2, regwrite, memread, memwrite}
    typedef struct packed {
        logic        v;
        logic [31:0] inst, pc, rs, rt, imm;
        logic [3:0]  alu;
        logic [4:0]  ctrl;
        logic [4:0]  wa;
        logic        hz;
        logic [1:0]  frs, frt;
        logic [31:0] wb;
        logic        fl;
        logic        e_st;
        logic        e_v;
        logic [31:0] e_inst, e_pc, e_rs, e_rt, e_imm;
        logic [3:0]  e_alu;
        logic [4:0]  e_ctrl;
        logic [4:0]  e_wa;
        logic [15:0] e_sc, e_fc;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_id(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                            input logic [3:0] alu, input logic [4:0] ctrl, input logic [4:0] wa);
        ID_valid    = v;
        ID_inst     = inst;
        ID_pc       = pc;
        ID_rsdata   = rs;
        ID_rtdata   = rt;
        ID_imm      = imm;
        ID_aluop    = alu;
        ID_regread1 = ctrl[4];
        ID_regread2 = ctrl[3];
        ID_regwrite = ctrl[2];
        ID_memread  = ctrl[1];
        ID_memwrite = ctrl[0];
        ID_wraddr   = wa;
    endtask

    initial begin
        logic [4:0] ctrl_now;

        //          v  inst           pc      rs            rt            imm           alu   ctrl      wa     hz frs frt wb             fl   st ev e_inst         e_pc    e_rs          e_rt          e_imm         e_alu e_ctrl    e_wa   sc     fc
        // idle hazard: EX empty so hzdlu is ignored and the instruction loads
        vecs[0]  = '{1'b1, 32'h8C22_0004, 32'h40, 32'h11, 32'h22, 32'h4, 4'h2, 5'b10110, 5'd2, 1'b1, 2'd0, 2'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 32'h8C22_0004, 32'h40, 32'h11, 32'h22, 32'h4, 4'h2, 5'b10110, 5'd2, 16'd0, 16'd0};
        // plain pass-through
        vecs[1]  = '{1'b1, 32'h0022_1820, 32'h44, 32'h33, 32'h44, 32'h0, 4'h1, 5'b11100, 5'd3, 1'b0, 2'd0, 2'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 32'h0022_1820, 32'h44, 32'h33, 32'h44, 32'h0, 4'h1, 5'b11100, 5'd3, 16'd0, 16'd0};
        // load-use stall, rt captures WB
        vecs[2]  = '{1'b1, 32'h1234_5678, 32'h48, 32'h55, 32'h66, 32'hFFFF_FFF0, 4'h9, 5'b01011, 5'd31, 1'b1, 2'd0, 2'd2, 32'hDEAD_BEEF, 1'b0,
                     1'b1, 1'b1, 32'h0022_1820, 32'h44, 32'h33, 32'hDEAD_BEEF, 32'h0, 4'h1, 5'b11100, 5'd3, 16'd1, 16'd0};
        // second stall cycle, rs captures WB, MEM select on rt captures nothing
        vecs[3]  = '{1'b1, 32'h1234_5678, 32'h48, 32'h55, 32'h66, 32'hFFFF_FFF0, 4'h9, 5'b01011, 5'd31, 1'b1, 2'd2, 2'd1, 32'hCAFE_F00D, 1'b0,
                     1'b1, 1'b1, 32'h0022_1820, 32'h44, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0, 4'h1, 5'b11100, 5'd3, 16'd2, 16'd0};
        // third stall cycle, no WB selects: full hold
        vecs[4]  = '{1'b1, 32'h1234_5678, 32'h48, 32'h55, 32'h66, 32'hFFFF_FFF0, 4'h9, 5'b01011, 5'd31, 1'b1, 2'd1, 2'd0, 32'h0BAD_F00D, 1'b0,
                     1'b1, 1'b1, 32'h0022_1820, 32'h44, 32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h0, 4'h1, 5'b11100, 5'd3, 16'd3, 16'd0};
        // stall released: WB selects ignored, ID fields load
        vecs[5]  = '{1'b1, 32'h1234_5678, 32'h48, 32'h55, 32'h66, 32'hFFFF_FFF0, 4'h9, 5'b01011, 5'd31, 1'b0, 2'd2, 2'd2, 32'h1111_1111, 1'b0,
                     1'b0, 1'b1, 32'h1234_5678, 32'h48, 32'h55, 32'h66, 32'hFFFF_FFF0, 4'h9, 5'b01011, 5'd31, 16'd3, 16'd0};
        // flush beats stall: bubble, flush counted, stall not counted
        vecs[6]  = '{1'b1, 32'hAAAA_0000, 32'h4C, 32'h77, 32'h88, 32'h9, 4'h3, 5'b11111, 5'd9, 1'b1, 2'd2, 2'd2, 32'h2222_2222, 1'b1,
                     1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 5'b00000, 5'd0, 16'd3, 16'd1};
        // flush with EX already empty: not counted
        vecs[7]  = '{1'b1, 32'hAAAA_0000, 32'h4C, 32'h77, 32'h88, 32'h9, 4'h3, 5'b11111, 5'd9, 1'b0, 2'd0, 2'd0, 32'h0, 1'b1,
                     1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 5'b00000, 5'd0, 16'd3, 16'd1};
        // ID_valid=0 with non-zero fields: bubble
        vecs[8]  = '{1'b0, 32'hBBBB_0000, 32'h50, 32'h1, 32'h2, 32'h3, 4'hF, 5'b11111, 5'd7, 1'b0, 2'd0, 2'd0, 32'h0, 1'b0,
                     1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 5'b00000, 5'd0, 16'd3, 16'd1};
        vecs[9]  = '{1'b1, 32'h2001_0005, 32'h54, 32'h0, 32'h7, 32'h5, 4'h0, 5'b10100, 5'd1, 1'b0, 2'd0, 2'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 32'h2001_0005, 32'h54, 32'h0, 32'h7, 32'h5, 4'h0, 5'b10100, 5'd1, 16'd3, 16'd1};
        vecs[10] = '{1'b1, 32'h9999_9999, 32'h58, 32'hA, 32'hB, 32'hC, 4'h7, 5'b01010, 5'd4, 1'b1, 2'd0, 2'd0, 32'h3333_3333, 1'b0,
                     1'b1, 1'b1, 32'h2001_0005, 32'h54, 32'h0, 32'h7, 32'h5, 4'h0, 5'b10100, 5'd1, 16'd4, 16'd1};
        vecs[11] = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 5'b00000, 5'd0, 1'b0, 2'd0, 2'd0, 32'h0, 1'b0,
                     1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 5'b00000, 5'd0, 16'd4, 16'd1};

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        drive_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 5'b0, 5'd0);
        hzdlu = 1'b1; fwdrs = 2'd0; fwdrt = 2'd0; WB_wrdata = 32'h0; flush = 1'b0;
        #2;
        chk("reset EX_valid",  {31'b0, EX_valid}, 32'h0);
        chk("reset EX_inst",   EX_inst, 32'h0);
        chk("reset ID_stall",  {31'b0, ID_stall}, 32'h0);
        chk("reset stall_cnt", {16'b0, stall_cnt}, 32'h0);
        chk("reset flush_cnt", {16'b0, flush_cnt}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_id(vecs[i].v, vecs[i].inst, vecs[i].pc, vecs[i].rs, vecs[i].rt,
                     vecs[i].imm, vecs[i].alu, vecs[i].ctrl, vecs[i].wa);
            hzdlu = vecs[i].hz; fwdrs = vecs[i].frs; fwdrt = vecs[i].frt;
            WB_wrdata = vecs[i].wb; flush = vecs[i].fl;
            #1;
            chk($sformatf("v%0d ID_stall", i),  {31'b0, ID_stall},  {31'b0, vecs[i].e_st});
            chk($sformatf("v%0d EX_bubble", i), {31'b0, EX_bubble}, {31'b0, vecs[i].e_st});
            @(posedge clk);
            #1;
            ctrl_now = {EX_regread1, EX_regread2, EX_regwrite, EX_memread, EX_memwrite};
            chk($sformatf("v%0d EX_valid", i),  {31'b0, EX_valid}, {31'b0, vecs[i].e_v});
            chk($sformatf("v%0d EX_inst", i),   EX_inst,   vecs[i].e_inst);
            chk($sformatf("v%0d EX_pc", i),     EX_pc,     vecs[i].e_pc);
            chk($sformatf("v%0d EX_rsdata", i), EX_rsdata, vecs[i].e_rs);
            chk($sformatf("v%0d EX_rtdata", i), EX_rtdata, vecs[i].e_rt);
            chk($sformatf("v%0d EX_imm", i),    EX_imm,    vecs[i].e_imm);
            chk($sformatf("v%0d EX_aluop", i),  {28'b0, EX_aluop}, {28'b0, vecs[i].e_alu});
            chk($sformatf("v%0d EX_ctrl", i),   {27'b0, ctrl_now}, {27'b0, vecs[i].e_ctrl});
            chk($sformatf("v%0d EX_wraddr", i), {27'b0, EX_wraddr}, {27'b0, vecs[i].e_wa});
            chk($sformatf("v%0d stall_cnt", i), {16'b0, stall_cnt}, {16'b0, vecs[i].e_sc});
            chk($sformatf("v%0d flush_cnt", i), {16'b0, flush_cnt}, {16'b0, vecs[i].e_fc});
        end

        // ---------------- asynchronous reset mid-cycle ----------------
        @(negedge clk);
        drive_id(1'b1, 32'hC0DE_0001, 32'h60, 32'h1, 32'h2, 32'h3, 4'h5, 5'b10101, 5'd6);
        hzdlu = 1'b0; fwdrs = 2'd0; fwdrt = 2'd0; flush = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-reset EX_valid", {31'b0, EX_valid}, 32'h1);
        hzdlu = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset EX_valid",  {31'b0, EX_valid}, 32'h0);
        chk("async reset EX_inst",   EX_inst, 32'h0);
        chk("async reset EX_pc",     EX_pc, 32'h0);
        chk("async reset ID_stall",  {31'b0, ID_stall}, 32'h0);
        chk("async reset stall_cnt", {16'b0, stall_cnt}, 32'h0);
        chk("async reset flush_cnt", {16'b0, flush_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- reset during a stall ----------------
        hzdlu = 1'b0;
        drive_id(1'b1, 32'hAB00_0001, 32'h70, 32'h1, 32'h2, 32'h3, 4'h1, 5'b10000, 5'd8);
        @(posedge clk);
        @(negedge clk);
        hzdlu = 1'b1;
        drive_id(1'b1, 32'hAB00_0002, 32'h74, 32'h4, 32'h5, 32'h6, 4'h2, 5'b01000, 5'd9);
        #1;
        chk("midstall ID_stall", {31'b0, ID_stall}, 32'h1);
        @(posedge clk);
        #1;
        chk("midstall held inst", EX_inst, 32'hAB00_0001);
        chk("midstall stall_cnt", {16'b0, stall_cnt}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midstall reset EX_valid", {31'b0, EX_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_id(1'b1, 32'hAB00_0003, 32'h78, 32'h7, 32'h8, 32'h9, 4'h3, 5'b00100, 5'd10);
        #1;
        chk("post-reset ID_stall", {31'b0, ID_stall}, 32'h0);
        @(posedge clk);
        #1;
        chk("post-reset load inst", EX_inst, 32'hAB00_0003);
        chk("post-reset load pc",   EX_pc, 32'h78);
        chk("post-reset stall_cnt", {16'b0, stall_cnt}, 32'h0);

        // ---------------- stall counter saturation ----------------
        // hzdlu stays high with EX valid: every following edge is a stall.
        repeat (65534) @(posedge clk);
        #1;
        chk("sat stall_cnt at FFFE", {16'b0, stall_cnt}, 32'h0000_FFFE);
        @(posedge clk);
        #1;
        chk("sat stall_cnt at FFFF", {16'b0, stall_cnt}, 32'h0000_FFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("sat stall_cnt no wrap", {16'b0, stall_cnt}, 32'h0000_FFFF);
        chk("sat held inst",         EX_inst, 32'hAB00_0003);
        chk("sat ID_stall",          {31'b0, ID_stall}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
